// File: rtl/fp_pkg.sv
// Shared single-precision float definitions: field widths, packed-word layout,
// normaliser state encoding and the common {sign, exp, frac} packing helper.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 25;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int FRAC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_e;

  function automatic logic [WORD_W-1:0] fp_pack(input logic              s,
                                                input logic [EXP_W-1:0]  e,
                                                input logic [FRAC_W-1:0] f);
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[SIGN_POS]          = s;
    w[EXP_MSB:EXP_LSB]   = e;
    w[FRAC_MSB:FRAC_LSB] = f;
    return w;
  endfunction

endpackage

// File: rtl/fp_seq_normaliser.sv
// Post-add normalise-and-pack stage: shifts the mantissa left one bit per clock
// until the hidden bit is set (or the exponent bottoms out), then packs the word.
module fp_seq_normaliser
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_s,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [MANT_W-1:0] in_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_denorm
);

  norm_state_e       state_q, state_d;
  logic              s_q, s_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [MANT_W-1:0] m_q, m_d;
  logic              pass_q, pass_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              denorm_q, denorm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      e_q      <= '0;
      m_q      <= '0;
      pass_q   <= 1'b0;
      word_q   <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      e_q      <= e_d;
      m_q      <= m_d;
      pass_q   <= pass_d;
      word_q   <= word_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      denorm_q <= denorm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    e_d      = e_q;
    m_d      = m_q;
    pass_d   = pass_q;
    word_d   = word_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    denorm_d = denorm_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d      = in_s;
          e_d      = (in_e == '0) ? 8'd1 : in_e;
          m_d      = in_m;
          pass_d   = (in_e == EXP_MAX);
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          denorm_d = 1'b0;
          state_d  = NORM;
        end
      end
      NORM: begin
        // Priority order matters: Inf/NaN pass-through beats every other rule.
        state_d = DONE;
        if (pass_q) begin
          word_d = fp_pack(s_q, EXP_MAX, m_q[FRAC_W-1:0]);
        end else if (m_q == '0) begin
          word_d = '0;
          zero_d = 1'b1;
        end else if (m_q[MANT_W-1] && (e_q == EXP_MAX - 8'd1)) begin
          word_d = fp_pack(s_q, EXP_MAX, '0);
          ovf_d  = 1'b1;
        end else if (m_q[MANT_W-1]) begin
          e_d    = e_q + 8'd1;
          m_d    = m_q >> 1;
          word_d = fp_pack(s_q, e_q + 8'd1, m_q[FRAC_W:1]);
        end else if (m_q[FRAC_W]) begin
          word_d = fp_pack(s_q, e_q, m_q[FRAC_W-1:0]);
        end else if (e_q == 8'd1) begin
          word_d   = fp_pack(s_q, 8'd0, m_q[FRAC_W-1:0]);
          denorm_d = 1'b1;
        end else begin
          m_d     = m_q << 1;
          e_d     = e_q - 8'd1;
          state_d = NORM;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_word   = word_q;
  assign out_zero   = zero_q;
  assign out_ovf    = ovf_q;
  assign out_denorm = denorm_q;

endmodule

// File: tb/tb_fp_seq_normaliser.sv
// Directed and randomized bench for fp_seq_normaliser against an arithmetic
// reference model (leading-one search plus exponent budget).
module tb_fp_seq_normaliser;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [7:0]  in_e;
  logic [24:0] in_m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_zero;
  logic        out_ovf;
  logic        out_denorm;

  int total;
  int passed;

  fp_seq_normaliser dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_m      (in_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_denorm(out_denorm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: result follows from where the leading one sits and how far the
  // exponent can drop before hitting 1.
  task automatic model(input logic s, input logic [7:0] e_in, input logic [24:0] m,
                       output logic [31:0] w, output logic z, output logic o,
                       output logic d, output int lat);
    int          e;
    int          p;
    int          k;
    logic [24:0] ms;
    logic [7:0]  eo;
    e = (e_in == 8'd0) ? 1 : int'(e_in);
    z = 1'b0; o = 1'b0; d = 1'b0; lat = 1; w = 32'h0;
    if (e_in == 8'hFF) begin
      w = {s, 8'hFF, m[22:0]};
    end else if (m == 25'd0) begin
      z = 1'b1;
    end else if (m[24]) begin
      if (e == 254) begin
        w = {s, 8'hFF, 23'd0};
        o = 1'b1;
      end else begin
        eo = 8'(e + 1);
        w  = {s, eo, m[23:1]};
      end
    end else begin
      p = -1;
      for (int i = 23; i >= 0; i--) if (p < 0 && m[i]) p = i;
      k = 23 - p;
      if (e - k >= 1) begin
        ms  = m << k;
        eo  = 8'(e - k);
        w   = {s, eo, ms[22:0]};
        lat = 1 + k;
      end else begin
        k   = e - 1;
        ms  = m << k;
        w   = {s, 8'h00, ms[22:0]};
        d   = 1'b1;
        lat = 1 + k;
      end
    end
  endtask

  task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                       input int hold, input string tag);
    logic [31:0] ew;
    logic        ez, eo, ed;
    int          elat;
    int          cnt;
    model(s, e, m, ew, ez, eo, ed, elat);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_s = s; in_e = e; in_m = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'(elat));
    chk({tag, "_word"}, out_word, ew);
    chk({tag, "_flags"}, {29'd0, out_zero, out_ovf, out_denorm}, {29'd0, ez, eo, ed});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_s = ~s; in_e = 8'h10; in_m = 25'h0800001;
      @(posedge clk); #1;
      chk({tag, "_hold_word"}, out_word, ew);
      chk({tag, "_hold_state"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_release"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic        rs;
    logic [7:0]  re;
    logic [24:0] rm;
    int          cnt;
    total = 0; passed = 0;
    rst = 1'b1; in_valid = 1'b0; in_s = 1'b0; in_e = 8'd0; in_m = 25'd0; out_ready = 1'b0;
    #12;
    chk("rst_ready_valid", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    chk("rst_word", out_word, 32'h0);
    chk("rst_flags", {29'd0, out_zero, out_ovf, out_denorm}, 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op(1'b0, 8'h80, 25'h0C00000, 0, "normal");
    do_op(1'b0, 8'h7F, 25'h1000000, 0, "carry");
    do_op(1'b0, 8'h85, 25'h0000100, 0, "deep");
    do_op(1'b0, 8'h03, 25'h0000010, 0, "denorm");
    do_op(1'b1, 8'hFE, 25'h1000000, 0, "ovf");
    do_op(1'b1, 8'h90, 25'h0000000, 0, "zero");
    do_op(1'b1, 8'hFF, 25'h1234567, 0, "pass");
    do_op(1'b0, 8'h00, 25'h0000001, 0, "e0_denorm");
    do_op(1'b0, 8'h80, 25'h0C00000, 5, "backpressure");

    // Abort a long normalisation with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1; in_s = 1'b0; in_e = 8'h85; in_m = 25'h0000100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_state", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    chk("abort_word", out_word, 32'h0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("abort_no_output", 32'(cnt), 32'd0);

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom);
      re = 8'($urandom_range(0, 255));
      rm = 25'($urandom) >> $urandom_range(0, 25);
      do_op(rs, re, rm, int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
